// File: rtl/thermo_pattern_if.sv
// Request/response bundle between a pattern consumer (master) and the
// thermometer pattern generator (slave).
interface thermo_pattern_if #(
    parameter int WIDTH     = 32,
    parameter int BIN_WIDTH = 5
);
    logic                 bin_valid;
    logic                 bin_ready;
    logic [BIN_WIDTH-1:0] bin;
    logic                 ripple;
    logic [WIDTH-1:0]     thermo;
    logic [BIN_WIDTH-1:0] level;
    logic                 thermo_valid;
    logic                 busy;

    modport master (
        output bin_valid, bin, ripple,
        input  bin_ready, thermo, level, thermo_valid, busy
    );

    modport slave (
        input  bin_valid, bin, ripple,
        output bin_ready, thermo, level, thermo_valid, busy
    );
endinterface

// File: rtl/thermo_pattern_gen.sv
// Binary-to-thermometer pattern generator: loads a code directly or walks the
// pattern one bit per clock toward the target, pulsing thermo_valid on arrival.
module thermo_pattern_gen #(
    parameter int WIDTH     = 32,
    parameter int BIN_WIDTH = 5
) (
    input  logic            clk,
    input  logic            rst,
    thermo_pattern_if.slave tp
);
    typedef enum logic {IDLE, RIPPLE} state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     thermo_reg, thermo_next;
    logic [BIN_WIDTH-1:0] level_reg, level_next;
    logic [BIN_WIDTH-1:0] target_reg, target_next;
    logic                 valid_reg, valid_next;
    logic                 busy_reg, busy_next;

    logic [WIDTH-1:0]     decoded;
    logic [BIN_WIDTH-1:0] level_inc;
    logic [BIN_WIDTH-1:0] level_dec;
    logic                 accept;

    // Bit k of the pattern is set for every k below the requested code.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
        assign decoded[gi] = (BIN_WIDTH'(gi) < tp.bin);
    end

    assign level_inc = level_reg + BIN_WIDTH'(1);
    assign level_dec = level_reg - BIN_WIDTH'(1);

    assign tp.bin_ready    = (state_reg == IDLE) && !rst;
    assign accept          = tp.bin_valid && tp.bin_ready;
    assign tp.thermo       = thermo_reg;
    assign tp.level        = level_reg;
    assign tp.thermo_valid = valid_reg;
    assign tp.busy         = busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            thermo_reg <= '0;
            level_reg  <= '0;
            target_reg <= '0;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            thermo_reg <= thermo_next;
            level_reg  <= level_next;
            target_reg <= target_next;
            valid_reg  <= valid_next;
            busy_reg   <= busy_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        thermo_next = thermo_reg;
        level_next  = level_reg;
        target_next = target_reg;
        valid_next  = 1'b0;
        busy_next   = busy_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    target_next = tp.bin;
                    if (tp.ripple) begin
                        state_next = RIPPLE;
                        busy_next  = 1'b1;
                    end else begin
                        thermo_next = decoded;
                        level_next  = tp.bin;
                        valid_next  = 1'b1;
                    end
                end
            end
            RIPPLE: begin
                // Exactly one bit moves per edge, so the pattern never bubbles.
                if (level_reg < target_reg) begin
                    thermo_next[level_reg] = 1'b1;
                    level_next             = level_inc;
                    if (level_inc == target_reg) begin
                        valid_next = 1'b1;
                        state_next = IDLE;
                        busy_next  = 1'b0;
                    end
                end else if (level_reg > target_reg) begin
                    thermo_next[level_dec] = 1'b0;
                    level_next             = level_dec;
                    if (level_dec == target_reg) begin
                        valid_next = 1'b1;
                        state_next = IDLE;
                        busy_next  = 1'b0;
                    end
                end else begin
                    valid_next = 1'b1;
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_thermo_pattern_gen.sv
// Directed bench for thermo_pattern_gen: reset, direct sweep, ripple up/down,
// equal target, ignored requests and reset mid-ripple.
module tb_thermo_pattern_gen;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    thermo_pattern_if #(.WIDTH(32), .BIN_WIDTH(5)) tp ();

    thermo_pattern_gen #(.WIDTH(32), .BIN_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .tp  (tp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rip;
        logic [4:0]  bin;
        logic [31:0] exp_thermo;
        logic        exp_valid;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[32];

    function automatic logic [31:0] tmask(int n);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        return (n == 0) ? 32'h0 : (ones >> (32 - n));
    endfunction

    // Thermometer encoder: index of the first zero bit.
    function automatic int enc(logic [31:0] t);
        for (int i = 0; i < 32; i++)
            if (!t[i]) return i;
        return 32;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One edge, then compare every output against the expected state.
    task automatic step(string name, logic [31:0] et, logic ev, logic eb);
        tick();
        $display("%s: thermo=%h level=%0d valid=%b busy=%b ready=%b",
                 name, tp.thermo, tp.level, tp.thermo_valid, tp.busy, tp.bin_ready);
        chk({name, ".thermo"}, tp.thermo, et);
        chk({name, ".level"}, 32'(tp.level), 32'(enc(et)));
        chk({name, ".valid"}, 32'(tp.thermo_valid), 32'(ev));
        chk({name, ".busy"}, 32'(tp.busy), 32'(eb));
        chk({name, ".ready"}, 32'(tp.bin_ready), 32'(!eb));
    endtask

    task automatic request(logic rip, logic [4:0] b);
        tp.bin_valid = 1'b1;
        tp.ripple    = rip;
        tp.bin       = b;
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            vecs[i] = '{rip: 1'b0, bin: 5'(i), exp_thermo: tmask(i),
                        exp_valid: 1'b1, exp_busy: 1'b0};

        rst = 1'b1;
        request(1'b0, 5'd7);

        // Reset held three cycles with a pending request.
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("reset%0d: thermo=%h level=%0d ready=%b", i, tp.thermo, tp.level, tp.bin_ready);
            chk("reset.thermo", tp.thermo, 32'h0);
            chk("reset.level", 32'(tp.level), 32'h0);
            chk("reset.valid", 32'(tp.thermo_valid), 32'h0);
            chk("reset.busy", 32'(tp.busy), 32'h0);
            chk("reset.ready", 32'(tp.bin_ready), 32'h0);
        end
        rst = 1'b0;
        tp.bin_valid = 1'b0;
        #1;
        chk("post_reset.ready", 32'(tp.bin_ready), 32'h1);

        // Direct sweep, back-to-back.
        for (int i = 0; i < 32; i++) begin
            request(vecs[i].rip, vecs[i].bin);
            step($sformatf("direct%0d", i), vecs[i].exp_thermo, vecs[i].exp_valid, vecs[i].exp_busy);
            chk("direct.encode", 32'(enc(tp.thermo)), 32'(i));
        end
        request(1'b0, 5'd0);
        step("direct_zero", 32'h0, 1'b1, 1'b0);
        tp.bin_valid = 1'b0;
        step("idle", 32'h0, 1'b0, 1'b0);

        // Ripple up 0 -> 5.
        request(1'b1, 5'd5);
        step("up.E0", 32'h0, 1'b0, 1'b1);
        tp.bin_valid = 1'b0;
        step("up.E1", 32'h1, 1'b0, 1'b1);
        step("up.E2", 32'h3, 1'b0, 1'b1);
        step("up.E3", 32'h7, 1'b0, 1'b1);
        step("up.E4", 32'hF, 1'b0, 1'b1);
        step("up.E5", 32'h1F, 1'b1, 1'b0);
        step("up.after", 32'h1F, 1'b0, 1'b0);

        // Ripple 5 -> 9 while other requests are toggled in.
        request(1'b1, 5'd9);
        step("ign.E0", 32'h1F, 1'b0, 1'b1);
        request(1'b0, 5'd2);
        step("ign.E1", 32'h3F, 1'b0, 1'b1);
        tp.bin_valid = 1'b0;
        step("ign.E2", 32'h7F, 1'b0, 1'b1);
        request(1'b1, 5'd30);
        step("ign.E3", 32'hFF, 1'b0, 1'b1);
        tp.bin_valid = 1'b0;
        step("ign.E4", 32'h1FF, 1'b1, 1'b0);
        step("ign.after", 32'h1FF, 1'b0, 1'b0);

        // Ripple down 31 -> 28, then equal target.
        request(1'b0, 5'd31);
        step("load31", 32'h7FFF_FFFF, 1'b1, 1'b0);
        request(1'b1, 5'd28);
        step("down.E0", 32'h7FFF_FFFF, 1'b0, 1'b1);
        tp.bin_valid = 1'b0;
        step("down.E1", 32'h3FFF_FFFF, 1'b0, 1'b1);
        step("down.E2", 32'h1FFF_FFFF, 1'b0, 1'b1);
        step("down.E3", 32'h0FFF_FFFF, 1'b1, 1'b0);
        request(1'b1, 5'd28);
        step("eq.E0", 32'h0FFF_FFFF, 1'b0, 1'b1);
        tp.bin_valid = 1'b0;
        step("eq.E1", 32'h0FFF_FFFF, 1'b1, 1'b0);
        step("eq.after", 32'h0FFF_FFFF, 1'b0, 1'b0);

        // Reset during a 0 -> 20 ripple at level 9.
        request(1'b0, 5'd0);
        step("load0", 32'h0, 1'b1, 1'b0);
        request(1'b1, 5'd20);
        step("abort.E0", 32'h0, 1'b0, 1'b1);
        tp.bin_valid = 1'b0;
        for (int k = 1; k <= 9; k++)
            step($sformatf("abort.E%0d", k), tmask(k), 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        $display("abort.reset: thermo=%h level=%0d valid=%b", tp.thermo, tp.level, tp.thermo_valid);
        chk("abort.thermo", tp.thermo, 32'h0);
        chk("abort.level", 32'(tp.level), 32'h0);
        chk("abort.valid", 32'(tp.thermo_valid), 32'h0);
        chk("abort.busy", 32'(tp.busy), 32'h0);
        rst = 1'b0;
        step("abort.idle", 32'h0, 1'b0, 1'b0);
        request(1'b0, 5'd3);
        step("abort.direct3", 32'h7, 1'b1, 1'b0);
        tp.bin_valid = 1'b0;
        step("final", 32'h7, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
